inst_fetch_unit: RTL and testbench

//  Instruction-fetch stage ahead of the IF/ID register. Generates sequential PCs,

---
 rtl/inst_fetch_unit_pkg.sv | 15 +
 rtl/inst_fetch_unit_fifo.sv | 59 +++++
 rtl/inst_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_inst_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit.
// Build option: define FETCH_STATS_EN to add the fetch/flush statistics counters.
package inst_fetch_unit_pkg;

  localparam logic [31:0] NOP_INST        = 32'h0000_0033;
  // Wide enough for any XLEN up to 64; users slice the low XLEN bits.
  localparam logic [63:0] INST_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// Synchronous prefetch FIFO with flush; head is read combinationally from the
// registered storage so a pushed word is visible to the consumer the next cycle.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count     = wr_ptr_q - rd_ptr_q;
  assign head_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: sequential PC generation, one-outstanding imem reads,
// prefetch FIFO to decode, redirect flush. Optional stats under FETCH_STATS_EN.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]     stat_fetched,
  output logic [31:0]     stat_flushed
`endif
);

  localparam int              AW         = $clog2(FIFO_DEPTH);
  localparam int              CW         = AW + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = INST_ALIGN_MASK[XLEN-1:0];
  localparam logic [XLEN-1:0] NOP        = XLEN'(NOP_INST);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] issue_pc_q, issue_pc_d;

  logic            fifo_push, fifo_pop;
  logic            fifo_empty, fifo_full;
  logic [AW:0]     fifo_count;
  logic [XLEN-1:0] head_pc, head_inst;
  logic            outstanding;
  logic [CW:0]     committed;
  logic            credit_ok;

  fetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({issue_pc_q, imem_rdata}),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .head_data ({head_pc, head_inst}),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // Buffered entries plus the word still in flight must leave room for a response.
  assign outstanding = (state_q != IDLE);
  assign committed   = {1'b0, fifo_count} + {{CW{1'b0}}, outstanding};
  assign credit_ok   = (committed < (CW+1)'(FIFO_DEPTH)) && !fifo_full;

  assign if_valid  = !fifo_empty && !redirect_valid;
  assign if_inst   = if_valid ? head_inst : NOP;
  assign if_pc     = if_valid ? head_pc : '0;
  assign fifo_pop  = if_valid && if_ready;
  assign imem_addr = fetch_pc_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    issue_pc_d = issue_pc_q;
    imem_req   = 1'b0;
    fifo_push  = 1'b0;
    case (state_q)
      IDLE: begin
        imem_req = rst && credit_ok && !redirect_valid;
        if (imem_req && imem_gnt) begin
          state_d    = WAIT;
          issue_pc_d = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          // A response arriving with the redirect is simply dropped.
          state_d = imem_rvalid ? IDLE : DRAIN;
        end else if (imem_rvalid) begin
          fifo_push = 1'b1;
          state_d   = IDLE;
        end
      end
      DRAIN: begin
        if (imem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ALIGN_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      issue_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      issue_pc_q <= issue_pc_d;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_fetched_d;
  logic [31:0] stat_flushed_q, stat_flushed_d;

  // A redirect discards every buffered entry plus the word owed in WAIT;
  // in DRAIN that word was already counted by the earlier redirect.
  always_comb begin
    stat_fetched_d = stat_fetched_q + 32'(fifo_push);
    stat_flushed_d = stat_flushed_q;
    if (redirect_valid) begin
      stat_flushed_d = stat_flushed_q + 32'(fifo_count) + 32'(state_q == WAIT);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_fetched_q <= '0;
      stat_flushed_q <= '0;
    end else begin
      stat_fetched_q <= stat_fetched_d;
      stat_flushed_q <= stat_flushed_d;
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_flushed = stat_flushed_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed vector table, corner-case
// sequences and randomized traffic against a transaction-level queue model.
module tb_inst_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0033;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_flushed;
`endif

  inst_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_inst        (if_inst),
    .if_pc          (if_pc)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_flushed   (stat_flushed)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // ---------------- reference model: a queue of {pc, inst} plus the memory's pending read
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  bit          pend;
  bit          stale;
  logic [31:0] pend_pc;
  int          dly;
  logic [31:0] m_fetch;
  int          m_fetched;
  int          m_flushed;
  int          dut_grants;
  logic [31:0] dut_addrs[$];

  task automatic do_reset();
    rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_inst", if_inst, NOP);
    chk("rst_pc", if_pc, 32'h0);
`ifdef FETCH_STATS_EN
    chk("rst_stat_fetched", stat_fetched, 32'h0);
    chk("rst_stat_flushed", stat_flushed, 32'h0);
`endif
    rst = 1'b1;
    mq.delete();
    pend = 0; stale = 0; dly = 0; pend_pc = '0;
    m_fetch = 32'h0; m_fetched = 0; m_flushed = 0;
  endtask

  // One clock of model-checked traffic; starts and ends at a falling edge.
  task automatic model_cycle(input bit gnt_i, input bit rdy_i, input bit rdr_i,
                             input logic [31:0] rpc_i, input int lat);
    bit          rv;
    bit          exp_valid;
    bit          exp_req;
    rv = pend && (dly == 0);
    imem_gnt = gnt_i; if_ready = rdy_i; redirect_valid = rdr_i; redirect_pc = rpc_i;
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(pend_pc) : $urandom;
    #1;
    exp_valid = (mq.size() > 0) && !rdr_i;
    exp_req   = !pend && (mq.size() < DEPTH) && !rdr_i;
    chk("if_valid", if_valid, exp_valid);
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, m_fetch);
    chk("if_pc", if_pc, exp_valid ? mq[0].pc : 32'h0);
    chk("if_inst", if_inst, exp_valid ? mq[0].inst : NOP);
    if (imem_req === 1'b1 && gnt_i) begin
      dut_grants++;
      dut_addrs.push_back(imem_addr);
    end
    @(posedge clk);
    if (rdr_i) begin
      m_flushed += mq.size() + ((pend && !stale) ? 1 : 0);
      mq.delete();
      if (pend) stale = 1;
      m_fetch = rpc_i & 32'hFFFF_FFFC;
    end else begin
      if (exp_valid && rdy_i) void'(mq.pop_front());
      if (rv && !stale) begin
        mq.push_back('{pc: pend_pc, inst: mem_word(pend_pc)});
        m_fetched++;
      end
    end
    if (rv) pend = 0;
    else if (pend) dly--;
    if (exp_req && gnt_i) begin
      pend = 1; stale = 0; pend_pc = m_fetch; dly = lat - 1;
      m_fetch = m_fetch + 32'd4;
    end
    @(negedge clk);
  endtask

  // ---------------- directed vector table
  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        rdr;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rd,
                              input logic rdy, input logic rdr, input logic [31:0] rpc,
                              input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep, input logic [31:0] ei);
    vec_t v;
    v.gnt = g; v.rv = rv; v.rdata = rd; v.rdy = rdy; v.rdr = rdr; v.rpc = rpc;
    v.e_req = er; v.e_addr = ea; v.e_val = ev; v.e_pc = ep; v.e_inst = ei;
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    //           gnt rv rdata          rdy rdr rpc           req addr          val pc            inst
    tbl[0]  = mk(1, 0, 32'h0,          1,  0,  32'h0,        1,  32'h0,        0,  32'h0,        NOP);
    tbl[1]  = mk(1, 1, 32'hC0DE_0000,  1,  0,  32'h0,        0,  32'h0,        0,  32'h0,        NOP);
    tbl[2]  = mk(1, 0, 32'h0,          1,  0,  32'h0,        1,  32'h4,        1,  32'h0,        32'hC0DE_0000);
    tbl[3]  = mk(1, 1, 32'hC0DE_0004,  1,  0,  32'h0,        0,  32'h0,        0,  32'h0,        NOP);
    tbl[4]  = mk(1, 0, 32'h0,          1,  0,  32'h0,        1,  32'h8,        1,  32'h4,        32'hC0DE_0004);
    tbl[5]  = mk(1, 0, 32'h0,          1,  1,  32'h103,      0,  32'h0,        0,  32'h0,        NOP);
    tbl[6]  = mk(1, 1, 32'hC0DE_0008,  1,  0,  32'h0,        0,  32'h0,        0,  32'h0,        NOP);
    tbl[7]  = mk(1, 0, 32'h0,          1,  0,  32'h0,        1,  32'h100,      0,  32'h0,        NOP);
    tbl[8]  = mk(1, 1, 32'hC0DE_0100,  1,  1,  32'h200,      0,  32'h0,        0,  32'h0,        NOP);
    tbl[9]  = mk(0, 0, 32'h0,          1,  0,  32'h0,        1,  32'h200,      0,  32'h0,        NOP);
    tbl[10] = mk(0, 0, 32'h0,          1,  0,  32'h0,        1,  32'h200,      0,  32'h0,        NOP);
    tbl[11] = mk(0, 0, 32'h0,          1,  0,  32'h0,        1,  32'h200,      0,  32'h0,        NOP);
    tbl[12] = mk(0, 0, 32'h0,          1,  0,  32'h0,        1,  32'h200,      0,  32'h0,        NOP);
    tbl[13] = mk(0, 0, 32'h0,          1,  0,  32'h0,        1,  32'h200,      0,  32'h0,        NOP);
    tbl[14] = mk(1, 0, 32'h0,          1,  0,  32'h0,        1,  32'h200,      0,  32'h0,        NOP);
    tbl[15] = mk(1, 1, 32'hC0DE_0200,  0,  0,  32'h0,        0,  32'h0,        0,  32'h0,        NOP);
    tbl[16] = mk(1, 0, 32'h0,          0,  0,  32'h0,        1,  32'h204,      1,  32'h200,      32'hC0DE_0200);

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 17; i++) begin
      imem_gnt = tbl[i].gnt; imem_rvalid = tbl[i].rv; imem_rdata = tbl[i].rdata;
      if_ready = tbl[i].rdy; redirect_valid = tbl[i].rdr; redirect_pc = tbl[i].rpc;
      #1;
      chk($sformatf("tbl[%0d].req", i), imem_req, tbl[i].e_req);
      if (tbl[i].e_req) chk($sformatf("tbl[%0d].addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("tbl[%0d].valid", i), if_valid, tbl[i].e_val);
      chk($sformatf("tbl[%0d].pc", i), if_pc, tbl[i].e_pc);
      chk($sformatf("tbl[%0d].inst", i), if_inst, tbl[i].e_inst);
      $display("vec %0d: req=%b addr=%h if_valid=%b if_pc=%h if_inst=%h",
               i, imem_req, imem_addr, if_valid, if_pc, if_inst);
      @(negedge clk);
    end
`ifdef FETCH_STATS_EN
    chk("tbl_stat_fetched", stat_fetched, 32'd3);
    chk("tbl_stat_flushed", stat_flushed, 32'd2);
`endif

    // Fill with decode stalled: exactly DEPTH fetches, then one pop frees one slot.
    do_reset();
    dut_grants = 0;
    for (int i = 0; i < 20; i++) model_cycle(1, 0, 0, 32'h0, 1);
    chk("fill_grants", dut_grants, DEPTH);
    chk("fill_head_pc", if_pc, 32'h0);
    dut_grants = 0;
    model_cycle(1, 1, 0, 32'h0, 1);
    for (int i = 0; i < 8; i++) model_cycle(1, 0, 0, 32'h0, 1);
    chk("refill_grants", dut_grants, 1);
    $display("fill: grants after single pop=%0d", dut_grants);

    // Address wrap at the top of the address space.
    do_reset();
    dut_addrs.delete();
    model_cycle(0, 1, 1, 32'hFFFF_FFFF, 1);
    for (int i = 0; i < 6; i++) model_cycle(1, 1, 0, 32'h0, 1);
    if (dut_addrs.size() >= 2) begin
      chk("wrap_addr0", dut_addrs[0], 32'hFFFF_FFFC);
      chk("wrap_addr1", dut_addrs[1], 32'h0);
    end else begin
      chk("wrap_grant_count", dut_addrs.size(), 2);
    end

    // Reset while a read is in flight; the late response must be ignored.
    for (int k = 0; k < 10 && !pend; k++) model_cycle(1, 1, 0, 32'h0, 3);
    chk("midwait_setup", pend, 1'b1);
    do_reset();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0; if_ready = 1'b0;
    #1;
    chk("late_req", imem_req, 1'b1);
    chk("late_addr", imem_addr, 32'h0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    #1;
    chk("late_ignored_valid", if_valid, 1'b0);
    chk("late_ignored_inst", if_inst, NOP);
    $display("late rvalid after reset: if_valid=%b", if_valid);
    @(negedge clk);

    // Randomized traffic against the queue model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      model_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0, $urandom, $urandom_range(1, 3));
    end
`ifdef FETCH_STATS_EN
    chk("rand_stat_fetched", stat_fetched, m_fetched);
    chk("rand_stat_flushed", stat_flushed, m_flushed);
`endif
    $display("random: model fetched=%0d flushed=%0d", m_fetched, m_flushed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
